// File: rtl/sseg_display_ctrl.sv
// sseg_display_ctrl: binary-to-BCD formatter that writes sign, decimal point and digits into a seven-segment array
module sseg_display_ctrl #(
  parameter int SSEG_BITS = 2,
  parameter int SSEG_N    = 3,
  parameter int VAL_BITS  = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [VAL_BITS-1:0]  value,
  input  logic                 neg,
  input  logic                 dp_en,
  input  logic [SSEG_BITS-1:0] dp_sel,
  input  logic                 blank_lz,
  output logic                 busy,
  output logic                 done_tick,
  output logic                 ovf,
  output logic                 wr,
  output logic [SSEG_BITS-1:0] sel,
  output logic                 en,
  output logic                 sign,
  output logic                 dp,
  output logic [3:0]           val
);
  localparam int BW = 4 * SSEG_N;
  localparam int CW = $clog2(VAL_BITS + 1);
  typedef enum logic [1:0] {IDLE, CONV, WRITE, DONE} state_t;
  state_t state_q, state_d;
  logic [VAL_BITS-1:0] bin_q, bin_d;
  logic [BW-1:0] bcd_q, bcd_d, bcd_adj;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SSEG_BITS-1:0] idx_q, idx_d, dpsel_q, dpsel_d, sel_q, sel_d;
  logic neg_q, neg_d, dpen_q, dpen_d, blz_q, blz_d, stk_q, stk_d;
  logic busy_q, busy_d, done_q, done_d, ovf_q, ovf_d, wr_q, wr_d;
  logic en_q, en_d, sign_q, sign_d, dp_q, dp_d;
  logic [3:0] val_q, val_d, cur_dig;
  logic zh, cur_zh, ovf_f, blank;
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < SSEG_N; i++)
      bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] >= 4'd5 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    // zh tracks "this digit and everything above it is zero" for the digit being written
    zh = 1'b1;
    cur_zh = 1'b0;
    cur_dig = 4'd0;
    for (int i = SSEG_N - 1; i >= 0; i--) begin
      zh = zh & (bcd_q[4*i +: 4] == 4'd0);
      if (SSEG_BITS'(i) == idx_q) begin
        cur_zh = zh;
        cur_dig = bcd_q[4*i +: 4];
      end
    end
    ovf_f = stk_q | (neg_q & (bcd_q[BW-1 -: 4] != 4'd0));
    blank = blz_q & (idx_q != '0) & (~dpen_q | (idx_q > dpsel_q)) & cur_zh;
    state_d = state_q;
    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    dpsel_d = dpsel_q;
    neg_d = neg_q;
    dpen_d = dpen_q;
    blz_d = blz_q;
    stk_d = stk_q;
    busy_d = busy_q;
    done_d = 1'b0;
    ovf_d = ovf_q;
    wr_d = 1'b0;
    sel_d = sel_q;
    en_d = 1'b0;
    sign_d = 1'b0;
    dp_d = 1'b0;
    val_d = 4'd0;
    case (state_q)
      IDLE: begin
        busy_d = start;
        if (start) begin
          bin_d = value;
          neg_d = neg;
          dpen_d = dp_en;
          dpsel_d = dp_sel;
          blz_d = blank_lz;
          bcd_d = '0;
          stk_d = 1'b0;
          ovf_d = 1'b0;
          cnt_d = CW'(VAL_BITS);
          state_d = CONV;
        end
      end
      CONV: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        stk_d = stk_q | bcd_adj[BW-1];
        cnt_d = cnt_q - 1'b1;
        idx_d = '0;
        state_d = cnt_q == CW'(1) ? WRITE : CONV;
      end
      WRITE: begin
        wr_d = 1'b1;
        sel_d = idx_q;
        sign_d = ovf_f | (neg_q & (idx_q == SSEG_BITS'(SSEG_N - 1)));
        en_d = ~sign_d & ~blank;
        val_d = en_d ? cur_dig : 4'd0;
        dp_d = en_d & dpen_q & (dpsel_q == idx_q);
        idx_d = idx_q + 1'b1;
        state_d = idx_q == SSEG_BITS'(SSEG_N - 1) ? DONE : WRITE;
      end
      default: begin
        done_d = 1'b1;
        ovf_d = ovf_f;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      dpsel_q <= '0;
      neg_q <= 1'b0;
      dpen_q <= 1'b0;
      blz_q <= 1'b0;
      stk_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q <= 1'b0;
      wr_q <= 1'b0;
      sel_q <= '0;
      en_q <= 1'b0;
      sign_q <= 1'b0;
      dp_q <= 1'b0;
      val_q <= 4'd0;
    end else begin
      state_q <= state_d;
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      dpsel_q <= dpsel_d;
      neg_q <= neg_d;
      dpen_q <= dpen_d;
      blz_q <= blz_d;
      stk_q <= stk_d;
      busy_q <= busy_d;
      done_q <= done_d;
      ovf_q <= ovf_d;
      wr_q <= wr_d;
      sel_q <= sel_d;
      en_q <= en_d;
      sign_q <= sign_d;
      dp_q <= dp_d;
      val_q <= val_d;
    end
  end
  assign busy = busy_q;
  assign done_tick = done_q;
  assign ovf = ovf_q;
  assign wr = wr_q;
  assign sel = sel_q;
  assign en = en_q;
  assign sign = sign_q;
  assign dp = dp_q;
  assign val = val_q;
endmodule

// File: tb/tb_sseg_display_ctrl.sv
// tb_sseg_display_ctrl: directed and random requests checked against a decimal-arithmetic display model
module tb_sseg_display_ctrl;
  localparam int N = 3, VB = 10, SB = 2;
  logic clk = 1'b0, reset, start, neg, dp_en, blank_lz;
  logic [VB-1:0] value;
  logic [SB-1:0] dp_sel, sel;
  logic busy, done_tick, ovf, wr, en, sign, dp;
  logic [3:0] val;
  int total = 0, bad = 0;
  sseg_display_ctrl #(.SSEG_BITS(SB), .SSEG_N(N), .VAL_BITS(VB)) dut (
    .clk(clk), .reset(reset), .start(start), .value(value), .neg(neg), .dp_en(dp_en),
    .dp_sel(dp_sel), .blank_lz(blank_lz), .busy(busy), .done_tick(done_tick), .ovf(ovf),
    .wr(wr), .sel(sel), .en(en), .sign(sign), .dp(dp), .val(val)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done_tick, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_wr"}, wr, 0);
    chk({tag, "_sel"}, sel, 0);
    chk({tag, "_en"}, en, 0);
    chk({tag, "_sign"}, sign, 0);
    chk({tag, "_dp"}, dp, 0);
    chk({tag, "_val"}, val, 0);
  endtask
  // One request: the model works from decimal digits of v, not from any conversion steps
  task automatic run(input int v, input bit n, input bit de, input int ds, input bit bz, input bit extra);
    int wcnt, dcnt, d;
    bit ovf_e, e_sign, blank, e_en;
    wcnt = 0;
    dcnt = 0;
    @(negedge clk);
    value = VB'(v);
    neg = n;
    dp_en = de;
    dp_sel = SB'(ds);
    blank_lz = bz;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_acc", busy, 1);
    chk("ovf_clr", ovf, 0);
    value = VB'($urandom);
    neg = 1'($urandom);
    dp_en = 1'($urandom);
    dp_sel = SB'($urandom);
    blank_lz = 1'($urandom);
    ovf_e = (v >= 10**N) || (n && v >= 10**(N-1));
    for (int k = 1; k <= VB + N + 3; k++) begin
      start = extra && (k == 3 || k == VB + N + 1);
      @(posedge clk);
      #1;
      if (wr) begin
        d = (v / 10**wcnt) % 10;
        e_sign = ovf_e || (n && wcnt == N - 1);
        blank = !e_sign && bz && wcnt > 0 && (!de || wcnt > ds) && v < 10**wcnt;
        e_en = !e_sign && !blank;
        chk("wr_cycle", k, VB + 1 + wcnt);
        chk("sel", sel, wcnt);
        chk("en", en, e_en);
        chk("sign", sign, e_sign);
        chk("dp", dp, e_en && de && ds == wcnt);
        chk("val", val, e_en ? d : 0);
        wcnt++;
      end
      if (done_tick) begin
        dcnt++;
        chk("done_cycle", k, VB + N + 1);
        chk("ovf", ovf, ovf_e);
        chk("busy_done", busy, 1);
      end
      if (k == VB + N + 2) chk("busy_end", busy, 0);
    end
    start = 1'b0;
    chk("wr_count", wcnt, N);
    chk("done_count", dcnt, 1);
  endtask
  initial begin
    int wseen;
    reset = 1'b1;
    start = 1'b0;
    value = '0;
    neg = 1'b0;
    dp_en = 1'b0;
    dp_sel = '0;
    blank_lz = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
    run(147, 0, 1, 1, 1, 0);
    run(5, 0, 0, 0, 1, 0);
    run(5, 0, 1, 1, 1, 0);
    run(42, 1, 0, 0, 1, 0);
    run(123, 1, 0, 0, 1, 0);
    run(147, 0, 0, 0, 0, 0);
    run(1000, 0, 1, 0, 1, 0);
    run(0, 0, 1, 3, 1, 0);
    run(99, 1, 1, 0, 1, 0);
    run(999, 0, 1, 2, 1, 1);
    run(7, 0, 0, 0, 0, 1);
    // Abort mid-conversion
    @(negedge clk);
    value = VB'(321);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_idle_outputs("abort");
    @(negedge clk);
    reset = 1'b0;
    wseen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (wr || done_tick) wseen++;
    end
    chk("abort_quiet", wseen, 0);
    run(321, 0, 0, 0, 1, 0);
    for (int r = 0; r < 40; r++)
      run(int'($urandom_range(0, 1023)), 1'($urandom), 1'($urandom),
          int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
